// File: rtl/pipe_mem_ctrl_pkg.sv
// Shared definitions for the pipeline memory arbiter: FSM states, stall vectors, bus widths.
// No logic; constants only.
// Imported by pipe_mem_ctrl and its bench.
package pipe_mem_ctrl_pkg;

    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int SEL_W   = 4;
    localparam int STALL_W = 6;
    localparam int CNT_W   = 16;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        IF_BUSY = 3'd1,
        MS_BUSY = 3'd2,
        IF_RESP = 3'd3,
        MS_RESP = 3'd4,
        IF_DROP = 3'd5
    } state_t;

    // Stall vector bits: 0 PC, 1 IF, 2 ID, 3 EX, 4 MEM, 5 WB. A stage that
    // requests a hold also freezes every stage in front of it.
    localparam logic [STALL_W-1:0] STALL_NONE = 6'b000000;
    localparam logic [STALL_W-1:0] STALL_IF   = 6'b000011;
    localparam logic [STALL_W-1:0] STALL_ID   = 6'b000111;
    localparam logic [STALL_W-1:0] STALL_EX   = 6'b001111;
    localparam logic [STALL_W-1:0] STALL_MS   = 6'b011111;

endpackage

// File: rtl/pipe_mem_ctrl.sv
// Arbitrates IF fetches and MEM-stage accesses onto one single-port memory bus and drives pipeline stall/flush.
// Latency: bus request one cycle after issue decision; response visible one cycle after mem_ack, for one cycle.
// Backpressure: a requesting stage is held via stall until its response cycle; MEM has fixed priority over IF.
module pipe_mem_ctrl
    import pipe_mem_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stallreq_id,
    input  logic               stallreq_ex,
    input  logic               flush_req,
    input  logic               if_req,
    input  logic [ADDR_W-1:0]  if_addr,
    output logic [DATA_W-1:0]  if_inst,
    input  logic               ms_req,
    input  logic               ms_we,
    input  logic [ADDR_W-1:0]  ms_addr,
    input  logic [DATA_W-1:0]  ms_wdata,
    input  logic [SEL_W-1:0]   ms_sel,
    output logic [DATA_W-1:0]  ms_rdata,
    output logic               mem_req,
    output logic               mem_we,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic [DATA_W-1:0]  mem_wdata,
    output logic [SEL_W-1:0]   mem_sel,
    input  logic [DATA_W-1:0]  mem_rdata,
    input  logic               mem_ack,
    output logic [STALL_W-1:0] stall,
    output logic               flush,
    output logic               bus_err
);

    // Counter value seen in the last permitted wait cycle; only meaningful when MEM_TIMEOUT > 0.
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(MEM_TIMEOUT - 1);

    state_t            state;
    logic [DATA_W-1:0] rbuf;
    logic [CNT_W-1:0]  wait_cnt;
    logic              busy;
    logic              timeout_hit;
    logic              bus_done;
    logic              stallreq_ms;
    logic              stallreq_if;

    assign busy        = (state == IF_BUSY) || (state == MS_BUSY) || (state == IF_DROP);
    assign timeout_hit = (MEM_TIMEOUT != 0) && busy && !mem_ack && (wait_cnt == TO_LAST);
    assign bus_done    = busy && (mem_ack || timeout_hit);

    // A branch frozen in ID must not kill the fetch slot, so flush is gated by the ID hold.
    assign flush    = flush_req & ~stall[2];
    assign if_inst  = (state == IF_RESP) ? rbuf : '0;
    assign ms_rdata = (state == MS_RESP) ? rbuf : '0;

    // Stall priority: the oldest requesting stage wins and freezes everything younger.
    always_comb begin
        stallreq_ms = ms_req && (state != MS_RESP);
        stallreq_if = (if_req && (state != IF_RESP)) || (state == IF_DROP);
        stall       = STALL_NONE;
        if (stallreq_ms)      stall = STALL_MS;
        else if (stallreq_ex) stall = STALL_EX;
        else if (stallreq_id) stall = STALL_ID;
        else if (stallreq_if) stall = STALL_IF;
    end

    // Bus FSM: issue from IDLE, hold the bus until ack or timeout, then present the response for one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_sel   <= '0;
            rbuf      <= '0;
            wait_cnt  <= '0;
            bus_err   <= 1'b0;
        end else begin
            bus_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (ms_req) begin
                        state     <= MS_BUSY;
                        mem_req   <= 1'b1;
                        mem_we    <= ms_we;
                        mem_addr  <= ms_addr;
                        mem_wdata <= ms_wdata;
                        mem_sel   <= ms_sel;
                        wait_cnt  <= '0;
                    end else if (if_req) begin
                        state     <= IF_BUSY;
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b0;
                        mem_addr  <= if_addr;
                        mem_wdata <= '0;
                        mem_sel   <= 4'hF;
                        wait_cnt  <= '0;
                    end
                end
                IF_BUSY: begin
                    if (mem_ack) begin
                        state <= IF_RESP;
                        rbuf  <= mem_rdata;
                    end else if (flush) begin
                        state <= IF_DROP;
                    end
                end
                MS_BUSY: begin
                    if (mem_ack) begin
                        state <= MS_RESP;
                        rbuf  <= mem_rdata;
                    end
                end
                IF_DROP: begin
                    if (mem_ack) state <= IDLE;
                end
                IF_RESP, MS_RESP: state <= IDLE;
                default:          state <= IDLE;
            endcase

            if (busy) wait_cnt <= wait_cnt + 1'b1;

            // Abort overrides any BUSY/DROP transition chosen above.
            if (timeout_hit) begin
                state   <= IDLE;
                bus_err <= 1'b1;
            end

            if (bus_done) begin
                mem_req   <= 1'b0;
                mem_we    <= 1'b0;
                mem_addr  <= '0;
                mem_wdata <= '0;
                mem_sel   <= '0;
            end
        end
    end

endmodule

// File: tb/tb_pipe_mem_ctrl.sv
// Directed bench for pipe_mem_ctrl: instance a has no timeout, instance b uses MEM_TIMEOUT=4.
// Inputs driven 1 time unit after the rising edge, outputs sampled 1 unit later.
// Both instances share all inputs.
module tb_pipe_mem_ctrl;

    logic clk = 1'b0;
    logic rst;
    logic stallreq_id, stallreq_ex, flush_req;
    logic if_req, ms_req, ms_we, mem_ack;
    logic [31:0] if_addr, ms_addr, ms_wdata, mem_rdata;
    logic [3:0]  ms_sel;

    logic [31:0] if_inst_a, ms_rdata_a, mem_addr_a, mem_wdata_a;
    logic        mem_req_a, mem_we_a, flush_a, bus_err_a;
    logic [3:0]  mem_sel_a;
    logic [5:0]  stall_a;

    logic [31:0] if_inst_b, ms_rdata_b, mem_addr_b, mem_wdata_b;
    logic        mem_req_b, mem_we_b, flush_b, bus_err_b;
    logic [3:0]  mem_sel_b;
    logic [5:0]  stall_b;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pipe_mem_ctrl #(.MEM_TIMEOUT(0)) dut_a (
        .clk(clk), .rst(rst), .stallreq_id(stallreq_id), .stallreq_ex(stallreq_ex),
        .flush_req(flush_req), .if_req(if_req), .if_addr(if_addr), .if_inst(if_inst_a),
        .ms_req(ms_req), .ms_we(ms_we), .ms_addr(ms_addr), .ms_wdata(ms_wdata),
        .ms_sel(ms_sel), .ms_rdata(ms_rdata_a), .mem_req(mem_req_a), .mem_we(mem_we_a),
        .mem_addr(mem_addr_a), .mem_wdata(mem_wdata_a), .mem_sel(mem_sel_a),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack), .stall(stall_a), .flush(flush_a),
        .bus_err(bus_err_a)
    );

    pipe_mem_ctrl #(.MEM_TIMEOUT(4)) dut_b (
        .clk(clk), .rst(rst), .stallreq_id(stallreq_id), .stallreq_ex(stallreq_ex),
        .flush_req(flush_req), .if_req(if_req), .if_addr(if_addr), .if_inst(if_inst_b),
        .ms_req(ms_req), .ms_we(ms_we), .ms_addr(ms_addr), .ms_wdata(ms_wdata),
        .ms_sel(ms_sel), .ms_rdata(ms_rdata_b), .mem_req(mem_req_b), .mem_we(mem_we_b),
        .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b), .mem_sel(mem_sel_b),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack), .stall(stall_b), .flush(flush_b),
        .bus_err(bus_err_b)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        stallreq_id = 0; stallreq_ex = 0; flush_req = 0;
        if_req = 0; if_addr = '0;
        ms_req = 0; ms_we = 0; ms_addr = '0; ms_wdata = '0; ms_sel = '0;
        mem_ack = 0; mem_rdata = '0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1;
        step(); step();
        #1;
        total++; if (mem_req_a !== 1'b0)   begin bad++; $display("FAIL rst_mem_req got=%b exp=0", mem_req_a); end
        total++; if (mem_we_a !== 1'b0)    begin bad++; $display("FAIL rst_mem_we got=%b exp=0", mem_we_a); end
        total++; if (mem_addr_a !== 32'h0) begin bad++; $display("FAIL rst_mem_addr got=%h exp=0", mem_addr_a); end
        total++; if (mem_wdata_a !== 32'h0) begin bad++; $display("FAIL rst_mem_wdata got=%h exp=0", mem_wdata_a); end
        total++; if (mem_sel_a !== 4'h0)   begin bad++; $display("FAIL rst_mem_sel got=%h exp=0", mem_sel_a); end
        total++; if (stall_a !== 6'b0)     begin bad++; $display("FAIL rst_stall got=%b exp=000000", stall_a); end
        total++; if (flush_a !== 1'b0)     begin bad++; $display("FAIL rst_flush got=%b exp=0", flush_a); end
        total++; if (if_inst_a !== 32'h0)  begin bad++; $display("FAIL rst_if_inst got=%h exp=0", if_inst_a); end
        total++; if (ms_rdata_a !== 32'h0) begin bad++; $display("FAIL rst_ms_rdata got=%h exp=0", ms_rdata_a); end
        total++; if (bus_err_b !== 1'b0)   begin bad++; $display("FAIL rst_bus_err got=%b exp=0", bus_err_b); end
        rst = 0;
        step();
    endtask

    task automatic test_fetch();
        // cycle 0: request in IDLE
        if_req = 1; if_addr = 32'h100; #1;
        total++; if (stall_a !== 6'b000011) begin bad++; $display("FAIL fetch_stall_c0 got=%b exp=000011", stall_a); end
        total++; if (mem_req_a !== 1'b0)    begin bad++; $display("FAIL fetch_req_c0 got=%b exp=0", mem_req_a); end
        // cycles 1..3: bus held, ack in cycle 3
        for (int c = 1; c <= 3; c++) begin
            step();
            if (c == 3) begin mem_ack = 1; mem_rdata = 32'h3C010001; end
            #1;
            total++; if (mem_req_a !== 1'b1) begin bad++; $display("FAIL fetch_req_c%0d got=%b exp=1", c, mem_req_a); end
            total++; if (mem_addr_a !== 32'h100 || mem_sel_a !== 4'hF || mem_we_a !== 1'b0)
                begin bad++; $display("FAIL fetch_bus_c%0d got=%h/%h/%b exp=00000100/f/0", c, mem_addr_a, mem_sel_a, mem_we_a); end
            total++; if (stall_a !== 6'b000011) begin bad++; $display("FAIL fetch_stall_c%0d got=%b exp=000011", c, stall_a); end
            total++; if (if_inst_a !== 32'h0)   begin bad++; $display("FAIL fetch_inst_c%0d got=%h exp=0", c, if_inst_a); end
        end
        // cycle 4: IF_RESP
        step();
        mem_ack = 0; mem_rdata = '0; #1;
        total++; if (if_inst_a !== 32'h3C010001) begin bad++; $display("FAIL fetch_inst_resp got=%h exp=3c010001", if_inst_a); end
        total++; if (mem_req_a !== 1'b0)  begin bad++; $display("FAIL fetch_req_resp got=%b exp=0", mem_req_a); end
        total++; if (mem_addr_a !== 32'h0) begin bad++; $display("FAIL fetch_addr_resp got=%h exp=0", mem_addr_a); end
        total++; if (stall_a !== 6'b0)    begin bad++; $display("FAIL fetch_stall_resp got=%b exp=000000", stall_a); end
        if_req = 0;
        // cycle 5: response gone
        step(); #1;
        total++; if (if_inst_a !== 32'h0) begin bad++; $display("FAIL fetch_inst_after got=%h exp=0", if_inst_a); end
        clear_inputs();
        step();
    endtask

    task automatic test_priority();
        if_req = 1; if_addr = 32'h200;
        ms_req = 1; ms_we = 1; ms_addr = 32'h400; ms_wdata = 32'hDEADBEEF; ms_sel = 4'h3; #1;
        total++; if (stall_a !== 6'b011111) begin bad++; $display("FAIL prio_stall_c0 got=%b exp=011111", stall_a); end
        step();
        mem_ack = 1; mem_rdata = 32'h11112222; #1;
        total++; if (mem_addr_a !== 32'h400 || mem_we_a !== 1'b1 || mem_wdata_a !== 32'hDEADBEEF || mem_sel_a !== 4'h3)
            begin bad++; $display("FAIL prio_ms_bus got=%h/%b/%h/%h exp=00000400/1/deadbeef/3", mem_addr_a, mem_we_a, mem_wdata_a, mem_sel_a); end
        step();
        mem_ack = 0; mem_rdata = '0; #1;
        total++; if (ms_rdata_a !== 32'h11112222) begin bad++; $display("FAIL prio_ms_rdata got=%h exp=11112222", ms_rdata_a); end
        total++; if (stall_a !== 6'b000011) begin bad++; $display("FAIL prio_stall_msresp got=%b exp=000011", stall_a); end
        total++; if (mem_req_a !== 1'b0)    begin bad++; $display("FAIL prio_req_msresp got=%b exp=0", mem_req_a); end
        ms_req = 0;
        step(); #1;
        total++; if (mem_req_a !== 1'b0)    begin bad++; $display("FAIL prio_req_idle got=%b exp=0", mem_req_a); end
        step();
        mem_ack = 1; mem_rdata = 32'hCAFE0001; #1;
        total++; if (mem_req_a !== 1'b1 || mem_addr_a !== 32'h200 || mem_we_a !== 1'b0 || mem_sel_a !== 4'hF)
            begin bad++; $display("FAIL prio_if_bus got=%b/%h/%b/%h exp=1/00000200/0/f", mem_req_a, mem_addr_a, mem_we_a, mem_sel_a); end
        step();
        mem_ack = 0; if_req = 0; #1;
        total++; if (if_inst_a !== 32'hCAFE0001) begin bad++; $display("FAIL prio_if_inst got=%h exp=cafe0001", if_inst_a); end
        clear_inputs();
        step();
    endtask

    task automatic test_flush_drop();
        if_req = 1; if_addr = 32'h300;
        step();
        flush_req = 1; #1;
        total++; if (flush_a !== 1'b1) begin bad++; $display("FAIL drop_flush got=%b exp=1", flush_a); end
        step();
        flush_req = 0; if_addr = 32'h340; #1;
        total++; if (stall_a !== 6'b000011) begin bad++; $display("FAIL drop_stall got=%b exp=000011", stall_a); end
        total++; if (mem_req_a !== 1'b1 || mem_addr_a !== 32'h300) begin bad++; $display("FAIL drop_bus_held got=%b/%h exp=1/00000300", mem_req_a, mem_addr_a); end
        step();
        mem_ack = 1; mem_rdata = 32'hBAD0BAD0; #1;
        total++; if (if_inst_a !== 32'h0) begin bad++; $display("FAIL drop_inst_ack got=%h exp=0", if_inst_a); end
        step();
        mem_ack = 0; mem_rdata = '0; #1;
        total++; if (if_inst_a !== 32'h0 || mem_req_a !== 1'b0) begin bad++; $display("FAIL drop_discard got=%h/%b exp=0/0", if_inst_a, mem_req_a); end
        step();
        mem_ack = 1; mem_rdata = 32'h42; #1;
        total++; if (mem_req_a !== 1'b1 || mem_addr_a !== 32'h340) begin bad++; $display("FAIL drop_reissue got=%b/%h exp=1/00000340", mem_req_a, mem_addr_a); end
        step();
        mem_ack = 0; if_req = 0; #1;
        total++; if (if_inst_a !== 32'h42) begin bad++; $display("FAIL drop_new_inst got=%h exp=00000042", if_inst_a); end
        clear_inputs();
        step();
    endtask

    task automatic test_ex_stall();
        stallreq_ex = 1; if_req = 1; if_addr = 32'h500; flush_req = 1; #1;
        total++; if (stall_a !== 6'b001111) begin bad++; $display("FAIL ex_stall got=%b exp=001111", stall_a); end
        total++; if (flush_a !== 1'b0)      begin bad++; $display("FAIL ex_flush got=%b exp=0", flush_a); end
        step();
        stallreq_ex = 0; stallreq_id = 1; mem_ack = 1; mem_rdata = 32'h55; #1;
        total++; if (stall_a !== 6'b000111) begin bad++; $display("FAIL id_stall got=%b exp=000111", stall_a); end
        total++; if (flush_a !== 1'b0)      begin bad++; $display("FAIL id_flush got=%b exp=0", flush_a); end
        step();
        mem_ack = 0; #1;
        total++; if (if_inst_a !== 32'h55) begin bad++; $display("FAIL ex_no_drop got=%h exp=00000055", if_inst_a); end
        clear_inputs();
        step();
    endtask

    task automatic test_flush_ack();
        if_req = 1; if_addr = 32'h600;
        step();
        flush_req = 1; mem_ack = 1; mem_rdata = 32'h77; #1;
        total++; if (flush_a !== 1'b1) begin bad++; $display("FAIL fa_flush got=%b exp=1", flush_a); end
        step();
        flush_req = 0; mem_ack = 0; if_req = 0; #1;
        total++; if (if_inst_a !== 32'h77) begin bad++; $display("FAIL fa_inst got=%h exp=00000077", if_inst_a); end
        clear_inputs();
        step();
    endtask

    task automatic test_timeout();
        ms_req = 1; ms_addr = 32'h800; ms_sel = 4'hF; #1;
        total++; if (stall_b !== 6'b011111) begin bad++; $display("FAIL to_stall got=%b exp=011111", stall_b); end
        step();
        ms_req = 0; #1;
        total++; if (mem_req_a !== 1'b1) begin bad++; $display("FAIL to_ms_drop_req got=%b exp=1", mem_req_a); end
        total++; if (mem_req_b !== 1'b1) begin bad++; $display("FAIL to_req_c1 got=%b exp=1", mem_req_b); end
        for (int c = 2; c <= 4; c++) begin
            step(); #1;
            total++; if (mem_req_b !== 1'b1 || bus_err_b !== 1'b0) begin bad++; $display("FAIL to_wait_c%0d got=%b/%b exp=1/0", c, mem_req_b, bus_err_b); end
        end
        step(); #1;
        total++; if (mem_req_b !== 1'b0)   begin bad++; $display("FAIL to_req_drop got=%b exp=0", mem_req_b); end
        total++; if (bus_err_b !== 1'b1)   begin bad++; $display("FAIL to_bus_err got=%b exp=1", bus_err_b); end
        total++; if (ms_rdata_b !== 32'h0 || mem_addr_b !== 32'h0) begin bad++; $display("FAIL to_clean got=%h/%h exp=0/0", ms_rdata_b, mem_addr_b); end
        total++; if (mem_req_a !== 1'b1 || bus_err_a !== 1'b0) begin bad++; $display("FAIL to_notimeout got=%b/%b exp=1/0", mem_req_a, bus_err_a); end
        step();
        mem_ack = 1; mem_rdata = 32'h9999; #1;
        total++; if (bus_err_b !== 1'b0 || mem_req_b !== 1'b0) begin bad++; $display("FAIL to_pulse got=%b/%b exp=0/0", bus_err_b, mem_req_b); end
        step();
        mem_ack = 0; mem_rdata = '0; #1;
        total++; if (ms_rdata_a !== 32'h9999) begin bad++; $display("FAIL to_late_a got=%h exp=00009999", ms_rdata_a); end
        total++; if (ms_rdata_b !== 32'h0 || mem_req_b !== 1'b0) begin bad++; $display("FAIL to_late_b got=%h/%b exp=0/0", ms_rdata_b, mem_req_b); end
        clear_inputs();
        step();
    endtask

    task automatic test_reset_mid();
        ms_req = 1; ms_addr = 32'h700; ms_wdata = 32'h1234; ms_we = 1; ms_sel = 4'hF;
        step();
        #1;
        total++; if (mem_req_a !== 1'b1) begin bad++; $display("FAIL rm_busy got=%b exp=1", mem_req_a); end
        clear_inputs(); rst = 1;
        step();
        rst = 0; mem_ack = 1; mem_rdata = 32'hABCD; #1;
        total++; if (mem_req_a !== 1'b0 || mem_addr_a !== 32'h0 || mem_wdata_a !== 32'h0 || mem_we_a !== 1'b0)
            begin bad++; $display("FAIL rm_bus got=%b/%h/%h/%b exp=0/0/0/0", mem_req_a, mem_addr_a, mem_wdata_a, mem_we_a); end
        step();
        mem_ack = 0; mem_rdata = '0; #1;
        total++; if (ms_rdata_a !== 32'h0) begin bad++; $display("FAIL rm_no_resp got=%h exp=0", ms_rdata_a); end
        total++; if (stall_a !== 6'b0 || flush_a !== 1'b0 || if_inst_a !== 32'h0) begin bad++; $display("FAIL rm_outs got=%b/%b/%h exp=0/0/0", stall_a, flush_a, if_inst_a); end
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_fetch();
        test_priority();
        test_flush_drop();
        test_ex_stall();
        test_flush_ack();
        test_timeout();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipe_mem_ctrl.md
PIPE_MEM_CTRL -- requirements
Module: pipe_mem_ctrl

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 0: 0 means no timeout; otherwise, the ack-wait cycle limit before abort.
REQ-002 clk  in  1  clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 stallreq_id  in  1  ID stage hold request (load-use).
REQ-005 stallreq_ex  in  1  EX stage hold request (multi-cycle op).
REQ-006 flush_req  in  1  ID branch mispredict; discard instruction currently in IF.
REQ-007 if_req, if_addr  in  1, 32  instruction fetch request and word address.
REQ-008 if_inst  out  32  fetched instruction, valid in IF_RESP only, else 0.
REQ-009 ms_req, ms_we, ms_addr, ms_wdata, ms_sel  in  1,1,32,32,4  MEM-stage data access.
REQ-010 ms_rdata  out  32  load data, valid in MS_RESP only, else 0.
REQ-011 mem_req, mem_we, mem_addr, mem_wdata, mem_sel  out  1,1,32,32,4  shared single-port memory bus, all registered.
REQ-012 mem_rdata, mem_ack  in  32, 1  memory response; ack is a one-cycle pulse.
REQ-013 stall  out  6  bit0 PC, bit1 IF, bit2 ID, bit3 EX, bit4 MEM, bit5 WB; 1 = hold.
REQ-014 flush  out  1  to IF/ID register, clears the fetched slot.
REQ-015 bus_err  out  1  one-cycle pulse on timeout abort.

Function
REQ-016 FSM states SHALL be IDLE, IF_BUSY, MS_BUSY, IF_RESP, MS_RESP, IF_DROP.
REQ-017 IDLE: ms_req -> MS_BUSY, latch ms_* onto mem_*, set mem_req; else if_req -> IF_BUSY, latch if_addr, mem_we=0, mem_sel=4'hF; MEM stage has fixed priority.
REQ-018 mem_req and mem_* SHALL remain stable from issue until the mem_ack cycle, then drop to 0 the next cycle.
REQ-019 IF_BUSY + mem_ack -> IF_RESP, capture mem_rdata into response buffer; MS_BUSY + mem_ack -> MS_RESP likewise.
REQ-020 IF_BUSY with flush asserted (flush_req & ~stall[2]) and no ack the same cycle -> IF_DROP; IF_DROP + mem_ack -> IDLE, data discarded.
REQ-021 IF_RESP and MS_RESP SHALL last exactly one cycle, then -> IDLE; no new bus request issued in a RESP cycle.
REQ-022 stallreq_ms = ms_req & state!=MS_RESP; stallreq_if = if_req & state!=IF_RESP, or state==IF_DROP.
REQ-023 stall SHALL be combinational, highest requesting stage wins: ms -> 6'b011111, ex -> 6'b001111, id -> 6'b000111, if -> 6'b000011, none -> 6'b000000.
REQ-024 flush = flush_req & ~stall[2]; a frozen branch in ID does not flush.
REQ-025 Simultaneous flush and mem_ack in IF_BUSY: go to IF_RESP, flush still output; IF/ID clears the slot.
REQ-026 MEM_TIMEOUT>0: a 16-bit wait counter, cleared on issue, incrementing each BUSY/DROP cycle; on reaching MEM_TIMEOUT, drop mem_req, pulse bus_err, and go -> IDLE; if_inst/ms_rdata stay 0.
REQ-027 ms_req deasserting while MS_BUSY SHALL NOT abort the bus cycle.

Reset
REQ-028 rst SHALL force state IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, mem_sel=0, buffer=0, counter=0, bus_err=0.
REQ-029 rst mid-transaction SHALL abandon it; a late mem_ack in IDLE SHALL be ignored.
REQ-030 Outputs during and after rst SHALL be stall=0 and flush=0 (requests are 0 in reset), with if_inst=0 and ms_rdata=0.

Structure
REQ-031 State encodings, stall vector constants (STALL_NONE/IF/ID/EX/MS) and bus width macros SHALL live in the shared defines file.
REQ-032 Single module; no sub-module. Stall priority encoding is a combinational block inside it.

Verification
REQ-033 if_req, addr 0x100, ack after 3 cycles with 0x3C010001 -> mem_req 3 cycles, stall=6'b000011 until IF_RESP, if_inst=0x3C010001 for 1 cycle.
REQ-034 if_req and ms_req raised in the same cycle -> MS issued first with stall=6'b011111; IF issued after MS_RESP.
REQ-035 flush_req during IF_BUSY, ack 2 cycles later -> IF_DROP, if_inst stays 0, fetch reissued from IDLE.
REQ-036 stallreq_ex=1 with if_req pending -> stall=6'b001111 and flush suppressed while stall[2]=1.
REQ-037 MEM_TIMEOUT=4 and no ack -> mem_req drops after 4 wait cycles, bus_err pulse, state IDLE.
REQ-038 rst asserted in MS_BUSY, ack on the next cycle -> all outputs 0 and no MS_RESP.
